// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction fetch front end.
// Walks the PC and reads each 32-bit instruction from a byte-wide registered RAM as four
// little-endian byte reads. Completed words are buffered with their PC in a small queue,
// and decode pops them through a valid/ready handshake.
//
// Ports:
//   clk_in      system clock, rising edge
//   rst_in      asynchronous active-low reset
//   rdy_in      global ready; low pauses the block with all state held
//   mem_din     RAM read data; reflects mem_a from the previous cycle
//   mem_a       RAM byte address
//   mem_wr      RAM write enable; always 0
//   jump_en     redirect request: flush the queue and reload the PC
//   jump_pc     redirect target; bits [1:0] are ignored
//   inst_valid  queue head valid
//   inst_ready  decode accepts the head this cycle
//   inst        head instruction word
//   inst_pc     head instruction PC
module inst_fetcher #(
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [7:0]            mem_din,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  jump_en,
    input  logic [31:0]           jump_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [31:0]           inst_pc
);

    localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    // Bk: byte k of the current word has been addressed and is waiting to be captured.
    typedef enum logic [2:0] {StIdle, StB0, StB1, StB2, StB3} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [23:0]     word_q, word_d;
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0] q_inst [QUEUE_DEPTH];
    logic [31:0] q_pc   [QUEUE_DEPTH];

    logic        push, pop, flush, start_ok;
    logic [CntW:0] occupancy;
    logic [2:0]  byte_off;

    logic unused_jump_lsb;
    assign unused_jump_lsb = ^jump_pc[1:0];

    assign mem_wr = 1'b0;

    // Handshake and gating. A redirect overrides both push and pop.
    always_comb begin
        flush = rdy_in && jump_en;
        pop   = rdy_in && !jump_en && (count_q != '0) && inst_ready;
        push  = rdy_in && !jump_en && (state_q == StB3);
        // The word being completed this edge still needs a slot; a same-cycle pop frees one.
        occupancy = {1'b0, count_q}
                  + (CntW + 1)'((state_q == StB3) ? 1 : 0)
                  - (CntW + 1)'(pop ? 1 : 0);
        start_ok  = occupancy < (CntW + 1)'(QUEUE_DEPTH);
    end

    // Address generation. While running, the byte after the pending one is issued so reads
    // pipeline with the registered RAM; while paused the pending byte's address is held so
    // mem_din still carries it when the block resumes.
    always_comb begin
        byte_off = 3'd0;
        unique case (state_q)
            StIdle:  byte_off = 3'd0;
            StB0:    byte_off = 3'd0;
            StB1:    byte_off = 3'd1;
            StB2:    byte_off = 3'd2;
            StB3:    byte_off = 3'd3;
            default: byte_off = 3'd0;
        endcase
        if (rdy_in && (state_q != StIdle)) begin
            byte_off = byte_off + 3'd1;
        end
        mem_a = fetch_pc_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(byte_off);
    end

    // Next-state logic for the byte FSM, PC, word assembly and queue pointers.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        word_d     = word_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (flush) begin
            state_d    = StIdle;
            fetch_pc_d = {jump_pc[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else if (rdy_in) begin
            unique case (state_q)
                StIdle: begin
                    if (start_ok) state_d = StB0;
                end
                StB0: begin
                    word_d[7:0] = mem_din;
                    state_d     = StB1;
                end
                StB1: begin
                    word_d[15:8] = mem_din;
                    state_d      = StB2;
                end
                StB2: begin
                    word_d[23:16] = mem_din;
                    state_d       = StB3;
                end
                StB3: begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = start_ok ? StB0 : StIdle;
                end
                default: state_d = StIdle;
            endcase
            if (push) tail_d = tail_q + PtrW'(1);
            if (pop)  head_d = head_q + PtrW'(1);
            count_d = count_q + CntW'(push ? 1 : 0) - CntW'(pop ? 1 : 0);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            word_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            word_q     <= word_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_in) begin
        if (push) begin
            q_inst[tail_q] <= {mem_din, word_q};
            q_pc[tail_q]   <= fetch_pc_q;
        end
    end

    always_comb begin
        inst_valid = (count_q != '0);
        inst       = inst_valid ? q_inst[head_q] : 32'h0;
        inst_pc    = inst_valid ? q_pc[head_q]   : 32'h0;
    end

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  mem_din;
    logic [16:0] mem_a;
    logic        mem_wr;
    logic        jump_en;
    logic [31:0] jump_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] ram [0:131071];

    inst_fetcher #(
        .ADDR_WIDTH (17),
        .RESET_PC   (32'h0),
        .QUEUE_DEPTH(4)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .mem_din   (mem_din),
        .mem_a     (mem_a),
        .mem_wr    (mem_wr),
        .jump_en   (jump_en),
        .jump_pc   (jump_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst      (inst),
        .inst_pc   (inst_pc)
    );

    always #5 clk_in = ~clk_in;

    // Registered read-only RAM.
    always @(posedge clk_in) mem_din <= ram[mem_a];

    // Little-endian word at a byte address, RAM address wrapping at 17 bits.
    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [16:0] a;
        a = pc[16:0];
        return {ram[a + 17'd3], ram[a + 17'd2], ram[a + 17'd1], ram[a]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk_in);
        cyc++;
    endtask

    // Returns at the negedge of cycle 0 with reset just released.
    task automatic do_reset();
        @(negedge clk_in);
        rst_in     = 1'b0;
        rdy_in     = 1'b1;
        jump_en    = 1'b0;
        jump_pc    = 32'h0;
        inst_ready = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        int          pops;

        for (int i = 0; i < 131072; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h13; ram[1] = 8'h00; ram[2] = 8'h50; ram[3] = 8'h00;
        ram[4] = 8'h93; ram[5] = 8'h00; ram[6] = 8'h10; ram[7] = 8'h00;

        // Free run from reset with decode always ready.
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) next_cyc();
            #1;
            if (c == 0) begin
                check("rst_mem_wr", 32'(mem_wr), 32'h0);
                check("rst_inst", inst, 32'h0);
                check("rst_inst_pc", inst_pc, 32'h0);
            end
            if (c <= 4) check($sformatf("t1_mem_a_c%0d", c), 32'(mem_a), 32'(c));
            check($sformatf("t1_valid_c%0d", c), 32'(inst_valid), 32'((c == 5) || (c == 9)));
            if (c == 5) begin
                check("t1_inst_w0", inst, 32'h00500013);
                check("t1_pc_w0", inst_pc, 32'h0);
            end
            if (c == 9) begin
                check("t1_inst_w1", inst, 32'h00100093);
                check("t1_pc_w1", inst_pc, 32'h4);
            end
        end

        // Decode stalled: queue fills to depth, fetch parks, then drains in order.
        do_reset();
        for (int c = 0; c <= 35; c++) begin
            if (c > 0) next_cyc();
            if (c == 30) inst_ready = 1'b1;
            #1;
            if (c == 20 || c == 29) begin
                check($sformatf("t2_park_mem_a_c%0d", c), 32'(mem_a), 32'd16);
                check($sformatf("t2_park_valid_c%0d", c), 32'(inst_valid), 32'h1);
                check($sformatf("t2_park_pc_c%0d", c), inst_pc, 32'h0);
            end
            if (c >= 30 && c <= 33) begin
                check($sformatf("t2_drain_valid_c%0d", c), 32'(inst_valid), 32'h1);
                check($sformatf("t2_drain_pc_c%0d", c), inst_pc, 32'(4 * (c - 30)));
                check($sformatf("t2_drain_inst_c%0d", c), inst, word_at(32'(4 * (c - 30))));
            end
            if (c == 31) check("t2_resume_mem_a", 32'(mem_a), 32'd17);
            if (c == 34) check("t2_empty_valid", 32'(inst_valid), 32'h0);
            if (c == 35) begin
                check("t2_w4_valid", 32'(inst_valid), 32'h1);
                check("t2_w4_pc", inst_pc, 32'd16);
                check("t2_w4_inst", inst, word_at(32'd16));
            end
        end

        // Redirect at edge 7 to 0x102.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) next_cyc();
            if (c == 6) begin
                jump_en = 1'b1;
                jump_pc = 32'h102;
            end
            if (c == 7) jump_en = 1'b0;
            #1;
            if (c == 6) check("t3_pre_valid", 32'(inst_valid), 32'h1);
            if (c == 7) begin
                check("t3_mem_a", 32'(mem_a), 32'h100);
                check("t3_flush_valid", 32'(inst_valid), 32'h0);
            end
            if (c == 11) check("t3_valid_c11", 32'(inst_valid), 32'h0);
            if (c == 12) begin
                check("t3_valid_c12", 32'(inst_valid), 32'h1);
                check("t3_pc", inst_pc, 32'h100);
                check("t3_inst", inst, word_at(32'h100));
            end
        end

        // Pause for 3 cycles while byte 1 is pending.
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) next_cyc();
            rdy_in = !(c >= 2 && c <= 4);
            #1;
            if (c >= 2 && c <= 4) check($sformatf("t4_hold_mem_a_c%0d", c), 32'(mem_a), 32'd1);
            if (c == 7) check("t4_valid_c7", 32'(inst_valid), 32'h0);
            if (c == 8) begin
                check("t4_valid_c8", 32'(inst_valid), 32'h1);
                check("t4_inst", inst, word_at(32'h0));
                check("t4_pc", inst_pc, 32'h0);
            end
        end

        // Redirect, pop request and push all on the same edge.
        tgt = $urandom;
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) next_cyc();
            if (c == 8) begin
                inst_ready = 1'b1;
                jump_en    = 1'b1;
                jump_pc    = tgt;
            end
            if (c == 9) jump_en = 1'b0;
            #1;
            if (c == 8) begin
                check("t5_pre_valid", 32'(inst_valid), 32'h1);
                check("t5_pre_pc", inst_pc, 32'h0);
            end
            if (c == 9) begin
                check("t5_flush_valid", 32'(inst_valid), 32'h0);
                check("t5_mem_a", 32'(mem_a), {15'h0, tgt[16:2], 2'b00});
            end
            if (c == 13) check("t5_valid_c13", 32'(inst_valid), 32'h0);
            if (c == 14) begin
                check("t5_valid_c14", 32'(inst_valid), 32'h1);
                check("t5_pc", inst_pc, {tgt[31:2], 2'b00});
                check("t5_inst", inst, word_at({tgt[31:2], 2'b00}));
            end
        end

        // Reset asserted mid-word in cycle 3, released 2 cycles later.
        do_reset();
        inst_ready = 1'b1;
        for (int c = 1; c <= 3; c++) next_cyc();
        rst_in = 1'b0;
        #1;
        check("t6_rst_mem_a", 32'(mem_a), 32'h0);
        check("t6_rst_valid", 32'(inst_valid), 32'h0);
        next_cyc();
        next_cyc();
        rst_in = 1'b1;
        cyc    = 0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) next_cyc();
            #1;
            if (c == 0) check("t6_rel_mem_a", 32'(mem_a), 32'h0);
            check($sformatf("t6_valid_c%0d", c), 32'(inst_valid), 32'(c == 5));
            if (c == 5) begin
                check("t6_pc", inst_pc, 32'h0);
                check("t6_inst", inst, word_at(32'h0));
            end
        end

        // Random ready/pause/redirect traffic against an in-order stream model.
        do_reset();
        exp_pc = 32'h0;
        pops   = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) next_cyc();
            rdy_in     = ($urandom_range(0, 9) != 0);
            inst_ready = ($urandom_range(0, 2) != 0);
            jump_en    = ($urandom_range(0, 49) == 0);
            jump_pc    = $urandom;
            #1;
            if (rdy_in && !jump_en && inst_valid && inst_ready) begin
                check("rand_pc", inst_pc, exp_pc);
                check("rand_inst", inst, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (rdy_in && jump_en) exp_pc = {jump_pc[31:2], 2'b00};
        end
        check("rand_min_pops", 32'(pops >= 200), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Instruction fetch front end of the RISC-V core: walks the program counter, reads each 32-bit instruction from the byte-wide unified RAM as four little-endian byte reads, and buffers completed words with their PC in a small instruction queue. The decode stage downstream pops words with a valid/ready handshake. The execute stage can redirect the fetcher by flushing the queue and reloading the PC.

## Interface
- ADDR_WIDTH, 17: RAM byte-address width.
- RESET_PC, 32'h0: PC fetched first after reset.
- QUEUE_DEPTH, 4: instruction queue entries; power of two, ≥2.
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; low = pause, all state held.
- mem_din  input  8  RAM read data; reflects mem_a from the previous cycle (registered RAM).
- mem_a  output  ADDR_WIDTH  RAM byte address.
- mem_wr  output  1  RAM write enable; tied 0 (read-only master).
- jump_en  input  1  redirect request, one cycle.
- jump_pc  input  32  redirect target; bits [1:0] ignored and forced 0.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decode accepts head this cycle.
- inst  output  32  head instruction word.
- inst_pc  output  32  head instruction PC.

## Operation
- Reset values: mem_a = RESET_PC[ADDR_WIDTH-1:0], mem_wr = 0, inst_valid = 0, inst = 0, inst_pc = 0, queue count = 0, fetch PC = RESET_PC, byte index = 0, no byte pending.
- Byte FSM states: IDLE, B0, B1, B2, B3.
  - IDLE: no address issued.
  - Bk: byte k of the current word is pending capture.
- Issue and capture:
  - Address fetch_pc+k is driven in one cycle; mem_din is captured on the next edge into bits [8k+7:8k].
  - Byte k of word n+1 is issued while byte 3 of word n is captured, so consecutive words overlap.
- Push: on capture of byte 3, {fetch_pc, assembled word} is written to the queue tail, and fetch_pc += 4 (32-bit wrap).
- Start of a new word:
  - Requires queue count + (word in flight ? 1 : 0) < QUEUE_DEPTH, counting a same-cycle pop as freeing a slot.
  - If the condition fails, the FSM goes to IDLE after byte 3 and mem_a holds fetch_pc.
  - Issue resumes in the first cycle the condition holds.
- Pop: when inst_valid && inst_ready, the head advances. inst, inst_pc and inst_valid reflect the new head in the next cycle.
- Simultaneous push and pop: count is unchanged.
  - Push into an empty queue: the word is visible the cycle after the push edge.
  - Push and pop on a full queue never occurs, because the start gate above prevents it.
- Redirect (jump_en high on an active edge):
  - Queue cleared (count = 0, inst_valid = 0 next cycle).
  - In-flight bytes discarded.
  - fetch_pc = {jump_pc[31:2], 2'b00}, mem_a = that address in the next cycle, FSM restarts at byte 0.
  - Priority: redirect beats push and pop in the same cycle.
- Pause (rdy_in low):
  - No register changes and no capture, push or pop; jump_en is ignored.
  - mem_a is forced to the pending byte's address (fetch_pc+k), so that mem_din holds that byte on resume.
- Wrap-around:
  - Queue pointers wrap modulo QUEUE_DEPTH.
  - mem_a = (fetch_pc + k)[ADDR_WIDTH-1:0]; upper PC bits are carried in inst_pc but not used for addressing.

## Timing
- Cycle 0 is the first cycle after reset release.
- Address issue: mem_a = PC in cycle 0, PC+1 in cycle 1, PC+2 in cycle 2, PC+3 in cycle 3.
- Byte captures occur on edges 2..5.
- First inst_valid = 1 in cycle 5.
- Steady-state throughput: one word per 4 cycles. With continuous inst_ready, inst_valid pulses one cycle in every 4.
- Redirect latency: jump_en at edge t → mem_a = target in cycle t → target word valid in cycle t+5.
- Pause of N cycles adds exactly N cycles to every latency above.
- Reset asserted mid-word: immediate return to reset values and no partial push.

## Test plan
- Reset then free run, RAM bytes 0..7 = 13 00 50 00 93 00 10 00, inst_ready = 1 → cycle 5: inst = 0x00500013, inst_pc = 0; cycle 9: inst = 0x00100093, inst_pc = 4.
- inst_ready = 0 from reset, QUEUE_DEPTH = 4 → exactly 4 pushes (PCs 0, 4, 8, 12); mem_a then stays at 16. Raise inst_ready → 4 in-order pops, then fetch resumes at PC 16.
- jump_en at edge 7 with jump_pc = 0x102 → queue empties; mem_a = 0x100 in cycle 7; word at 0x100 valid in cycle 12 with inst_pc = 0x100.
- rdy_in low for 3 cycles starting while byte 1 is pending → mem_a held at PC+1; assembled word correct; first inst_valid delayed to cycle 8.
- jump_en and inst_ready both high in the same cycle as a push → no pop, no push; queue empty next cycle.
- Reset asserted in cycle 3 and released 2 cycles later → all outputs at reset values; first word is valid 5 cycles after release, fetched again from RESET_PC.
